bonus_spawner: RTL and testbench
================================

Name: bonus_spawner

Overview:
- Multi-slot successor of the single bonus-item spawner.
- Manages NUM_SLOTS independent on-screen bonus items on the tile grid.
- Accepts random cell candidates and rejects cells that are blocked by the map or already occupied, requesting a new candidate when it rejects one.
- Ages each item in seconds, blinks it before it expires, and clears it on collection or expiry; feeds per-slot positions and draw enables to the VGA drawing/collision logic.

Parameters:
- NUM_SLOTS, 4, number of concurrent bonus items (1..8)
- GRID_X_BITS, 5, width of random cell X
- GRID_Y_BITS, 4, width of random cell Y
- CELL_SHIFT, 5, log2 of cell size in pixels (32)
- LIFETIME_SEC, 15, seconds an item lives
- BLINK_SEC, 3, final seconds in which the item blinks; must be less than LIFETIME_SEC
- MAX_RETRIES, 3, rejected candidates tolerated per spawn request before the request is dropped

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- one_sec  in  1  one-cycle pulse, once per second
- blink_tick  in  1  one-cycle pulse that toggles the blink phase
- matrixTopLeftX  in  11  pixel X of grid origin
- matrixTopLeftY  in  11  pixel Y of grid origin
- randomRise  in  1  candidate valid pulse
- inRandomX  in  GRID_X_BITS  candidate cell X
- inRandomY  in  GRID_Y_BITS  candidate cell Y
- map_blocked  in  1  map answer for query_x/query_y, valid the cycle after the query
- collision  in  NUM_SLOTS  per-slot collection hit
- query_x  out  GRID_X_BITS  cell sent to the map lookup
- query_y  out  GRID_Y_BITS  cell sent to the map lookup
- newRandom  out  1  one-cycle pulse requesting a fresh candidate
- randomX  out  NUM_SLOTS x 11  per-slot pixel X
- randomY  out  NUM_SLOTS x 11  per-slot pixel Y
- drawEn  out  NUM_SLOTS  per-slot draw enable
- collected  out  NUM_SLOTS  one-cycle pulse when a slot is cleared by collision
- expired  out  NUM_SLOTS  one-cycle pulse when a slot is cleared by timeout
- spawn_drop  out  1  one-cycle pulse when a request is abandoned

Behaviour:
- Reset (asynchronous): FSM to IDLE; all slots inactive with age 0 and cell (0,0); blink phase 0; retry count 0. Outputs drawEn, newRandom, collected, expired and spawn_drop are 0; query_x and query_y are 0.
- Pixel positions are combinational: randomX[i] = (cellX[i] << CELL_SHIFT) + matrixTopLeftX + 1, truncated to 11 bits. randomY[i] is formed the same way.
- FSM states:
  - IDLE: on randomRise, latch the candidate, clear the retry count, go to QUERY.
  - QUERY: drive query_x/query_y from the latched candidate for one cycle, go to CHECK.
  - CHECK: sample map_blocked. The candidate is rejected if map_blocked = 1 or the cell equals the cell of any active slot.
    - If accepted and a free slot exists: write the lowest-index free slot (active = 1, age = 0), go to IDLE.
    - If accepted but no slot is free: pulse spawn_drop, go to IDLE.
    - If rejected and retries < MAX_RETRIES: increment retries, pulse newRandom, go to WAIT_RAND.
    - If rejected and retries = MAX_RETRIES: pulse spawn_drop, go to IDLE.
  - WAIT_RAND: on randomRise, latch the candidate and go to QUERY.
- randomRise in QUERY or CHECK is ignored.
- Free-slot scan in CHECK uses slot state as registered at the start of that cycle. A slot cleared in the same cycle becomes available from the next cycle.
- Per slot, while active:
  - one_sec increments age.
  - If collision[i] = 1: clear the slot and pulse collected[i].
  - Otherwise, if one_sec = 1 and age = LIFETIME_SEC - 1: clear the slot and pulse expired[i].
  - Collision has priority over expiry in the same cycle.
  - collision[i] on an inactive slot is ignored.
- blink_tick toggles the global blink phase.
- drawEn[i] = active[i] AND (age < LIFETIME_SEC - BLINK_SEC OR blink phase = 1). drawEn is registered, so it follows slot state with 1-cycle latency.
- The age counter is sized by $clog2(LIFETIME_SEC + 1) and never wraps.

Decomposition:
- Shared package bonus_pkg: FSM state enum (IDLE, QUERY, CHECK, WAIT_RAND) and the slot struct typedef {active, cellX, cellY, age}.
- Sub-module bonus_slot: one item's lifetime, collision/expiry handling and blink gating; instantiated NUM_SLOTS times by a generate loop.
- The top level holds the FSM, the occupancy compare and the free-slot priority encoder.

Test Plan:
- Reset mid-operation: assert resetN low in WAIT_RAND with 2 slots active -> all drawEn = 0, FSM in IDLE, no pulses.
- Accepted spawn: top-left = (16,16), candidate (3,2), map_blocked = 0 -> slot 0 active; randomX = 113, randomY = 81; drawEn[0] = 1 two cycles after CHECK.
- Map rejection and retry: map_blocked = 1 for 3 candidates -> 3 newRandom pulses; 4th candidate clear -> slot written. With MAX_RETRIES = 3 and 4 blocked candidates -> spawn_drop, no slot written.
- Occupied cell and full slots: candidate equal to an active slot's cell -> rejected with newRandom. All 4 slots full with a clear candidate -> spawn_drop.
- Lifetime and blink: 12 one_sec pulses -> drawEn[0] follows blink phase. 15th pulse -> expired[0] = 1 for one cycle, then drawEn[0] = 0.
- Collision versus expiry in the same cycle: collision[1] together with the final one_sec -> collected[1] = 1, expired[1] = 0. collision[2] on an inactive slot -> no pulse.

Source files
------------

// File: rtl/bonus_pkg.sv
// Shared types for the multi-slot bonus spawner: FSM states and the slot
// record. The cell/age widths here bound the parameter range of the
// spawner and its slots.
package bonus_pkg;

    localparam int CELL_X_W     = 5;
    localparam int CELL_Y_W     = 4;
    localparam int LIFE_SEC_DEF = 15;
    localparam int AGE_W        = $clog2(LIFE_SEC_DEF + 1);

    typedef enum logic [1:0] {
        IDLE,
        QUERY,
        CHECK,
        WAIT_RAND
    } state_t;

    typedef struct packed {
        logic                active;
        logic [CELL_X_W-1:0] cell_x;
        logic [CELL_Y_W-1:0] cell_y;
        logic [AGE_W-1:0]    age;
    } slot_t;

endpackage

// File: rtl/bonus_spawner_if.sv
// Candidate / map-lookup handshake between the random source, the map and
// the spawner. The spawner takes the slave side.
interface bonus_spawner_if #(
    parameter int GRID_X_BITS = 5,
    parameter int GRID_Y_BITS = 4
);
    logic                   randomRise;
    logic [GRID_X_BITS-1:0] inRandomX;
    logic [GRID_Y_BITS-1:0] inRandomY;
    logic                   newRandom;
    logic [GRID_X_BITS-1:0] query_x;
    logic [GRID_Y_BITS-1:0] query_y;
    logic                   map_blocked;

    modport master (
        output randomRise, inRandomX, inRandomY, map_blocked,
        input  newRandom, query_x, query_y
    );

    modport slave (
        input  randomRise, inRandomX, inRandomY, map_blocked,
        output newRandom, query_x, query_y
    );
endinterface

// File: rtl/bonus_slot.sv
// One bonus item: holds its cell, ages in seconds, clears on collection or
// timeout and gates its draw enable with the blink phase near the end.
module bonus_slot
    import bonus_pkg::*;
#(
    parameter int GRID_X_BITS  = CELL_X_W,
    parameter int GRID_Y_BITS  = CELL_Y_W,
    parameter int LIFETIME_SEC = LIFE_SEC_DEF,
    parameter int BLINK_SEC    = 3
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   one_sec,
    input  logic                   blink_phase,
    input  logic                   collision,
    input  logic                   wr_en,
    input  logic [GRID_X_BITS-1:0] wr_x,
    input  logic [GRID_Y_BITS-1:0] wr_y,
    output logic                   active,
    output logic [CELL_X_W-1:0]    cell_x,
    output logic [CELL_Y_W-1:0]    cell_y,
    output logic                   draw_en,
    output logic                   collected,
    output logic                   expired
);

    slot_t st;

    assign active = st.active;
    assign cell_x = st.cell_x;
    assign cell_y = st.cell_y;

    // Slot lifetime: a write only ever targets a free slot, so it never
    // races a clear. Collision wins over expiry; age stops at LIFETIME-1.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            st        <= '0;
            collected <= 1'b0;
            expired   <= 1'b0;
        end else begin
            collected <= 1'b0;
            expired   <= 1'b0;
            if (wr_en) begin
                st.active <= 1'b1;
                st.age    <= '0;
                st.cell_x <= CELL_X_W'(wr_x);
                st.cell_y <= CELL_Y_W'(wr_y);
            end else if (st.active) begin
                if (collision) begin
                    st.active <= 1'b0;
                    st.age    <= '0;
                    collected <= 1'b1;
                end else if (one_sec) begin
                    if (st.age == AGE_W'(LIFETIME_SEC - 1)) begin
                        st.active <= 1'b0;
                        st.age    <= '0;
                        expired   <= 1'b1;
                    end else begin
                        st.age <= st.age + 1'b1;
                    end
                end
            end
        end
    end

    // Registered draw enable: solid while young, follows blink phase after.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) draw_en <= 1'b0;
        else         draw_en <= st.active &&
                                ((st.age < AGE_W'(LIFETIME_SEC - BLINK_SEC)) || blink_phase);
    end

endmodule

// File: rtl/bonus_spawner.sv
// Multi-slot bonus spawner: candidate FSM with map/occupancy rejection and
// bounded retries, free-slot priority encoder and per-slot pixel positions.
module bonus_spawner
    import bonus_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int GRID_X_BITS  = CELL_X_W,
    parameter int GRID_Y_BITS  = CELL_Y_W,
    parameter int CELL_SHIFT   = 5,
    parameter int LIFETIME_SEC = LIFE_SEC_DEF,
    parameter int BLINK_SEC    = 3,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        one_sec,
    input  logic                        blink_tick,
    input  logic [10:0]                 matrixTopLeftX,
    input  logic [10:0]                 matrixTopLeftY,
    bonus_spawner_if.slave              bus,
    input  logic [NUM_SLOTS-1:0]        collision,
    output logic [NUM_SLOTS-1:0][10:0]  randomX,
    output logic [NUM_SLOTS-1:0][10:0]  randomY,
    output logic [NUM_SLOTS-1:0]        drawEn,
    output logic [NUM_SLOTS-1:0]        collected,
    output logic [NUM_SLOTS-1:0]        expired,
    output logic                        spawn_drop
);

    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    state_t                   state, state_n;
    logic [GRID_X_BITS-1:0]   cand_x, cand_x_n;
    logic [GRID_Y_BITS-1:0]   cand_y, cand_y_n;
    logic [RW-1:0]            retries, retries_n;
    logic                     new_random, new_random_n, drop_n;
    logic                     blink_phase;
    logic [NUM_SLOTS-1:0]     slot_active, wr_en, free_hot;
    logic [NUM_SLOTS-1:0][CELL_X_W-1:0] slot_x;
    logic [NUM_SLOTS-1:0][CELL_Y_W-1:0] slot_y;
    logic                     any_free, occupied;

    assign bus.newRandom = new_random;
    assign bus.query_x   = (state == QUERY) ? cand_x : '0;
    assign bus.query_y   = (state == QUERY) ? cand_y : '0;

    // Occupancy compare and lowest-index free slot, from registered slot state.
    always_comb begin
        occupied = 1'b0;
        any_free = 1'b0;
        free_hot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_active[i] && slot_x[i] == CELL_X_W'(cand_x) &&
                slot_y[i] == CELL_Y_W'(cand_y))
                occupied = 1'b1;
            if (!slot_active[i] && !any_free) begin
                free_hot[i] = 1'b1;
                any_free    = 1'b1;
            end
        end
    end

    // Cell to pixel: one pixel inside the cell's top-left corner.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            randomX[i] = (11'(slot_x[i]) << CELL_SHIFT) + matrixTopLeftX + 11'd1;
            randomY[i] = (11'(slot_y[i]) << CELL_SHIFT) + matrixTopLeftY + 11'd1;
        end
    end

    // FSM and candidate registers; newRandom/spawn_drop are registered pulses.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            cand_x      <= '0;
            cand_y      <= '0;
            retries     <= '0;
            new_random  <= 1'b0;
            spawn_drop  <= 1'b0;
            blink_phase <= 1'b0;
        end else begin
            state       <= state_n;
            cand_x      <= cand_x_n;
            cand_y      <= cand_y_n;
            retries     <= retries_n;
            new_random  <= new_random_n;
            spawn_drop  <= drop_n;
            blink_phase <= blink_phase ^ blink_tick;
        end
    end

    // Next-state: latch candidates, judge them in CHECK, retry or drop.
    always_comb begin
        state_n      = state;
        cand_x_n     = cand_x;
        cand_y_n     = cand_y;
        retries_n    = retries;
        new_random_n = 1'b0;
        drop_n       = 1'b0;
        wr_en        = '0;
        case (state)
            IDLE: if (bus.randomRise) begin
                cand_x_n  = bus.inRandomX;
                cand_y_n  = bus.inRandomY;
                retries_n = '0;
                state_n   = QUERY;
            end
            QUERY: state_n = CHECK;
            CHECK: begin
                if (!bus.map_blocked && !occupied) begin
                    if (any_free) wr_en  = free_hot;
                    else          drop_n = 1'b1;
                    state_n = IDLE;
                end else if (retries < RW'(MAX_RETRIES)) begin
                    retries_n    = retries + 1'b1;
                    new_random_n = 1'b1;
                    state_n      = WAIT_RAND;
                end else begin
                    drop_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_RAND: if (bus.randomRise) begin
                cand_x_n = bus.inRandomX;
                cand_y_n = bus.inRandomY;
                state_n  = QUERY;
            end
            default: state_n = IDLE;
        endcase
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        bonus_slot #(
            .GRID_X_BITS (GRID_X_BITS),
            .GRID_Y_BITS (GRID_Y_BITS),
            .LIFETIME_SEC(LIFETIME_SEC),
            .BLINK_SEC   (BLINK_SEC)
        ) u_slot (
            .clk        (clk),
            .resetN     (resetN),
            .one_sec    (one_sec),
            .blink_phase(blink_phase),
            .collision  (collision[g]),
            .wr_en      (wr_en[g]),
            .wr_x       (cand_x),
            .wr_y       (cand_y),
            .active     (slot_active[g]),
            .cell_x     (slot_x[g]),
            .cell_y     (slot_y[g]),
            .draw_en    (drawEn[g]),
            .collected  (collected[g]),
            .expired    (expired[g])
        );
    end

endmodule

// File: tb/tb_bonus_spawner.sv
// Directed bench for bonus_spawner: pulse outputs are checked against an
// expected-event queue, levels (positions, draw enables) checked inline.
module tb_bonus_spawner;

    localparam int NS = 4;

    logic              clk = 1'b0;
    logic              resetN;
    logic              one_sec, blink_tick;
    logic [10:0]       tlx, tly;
    logic [NS-1:0]     collision;
    logic [NS-1:0][10:0] randomX, randomY;
    logic [NS-1:0]     drawEn, collected, expired;
    logic              spawn_drop;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    // event codes: 0 newRandom, 16 spawn_drop, 32+i collected, 48+i expired
    localparam int EV_NR = 0, EV_DROP = 16, EV_COL = 32, EV_EXP = 48;

    bonus_spawner_if #(.GRID_X_BITS(5), .GRID_Y_BITS(4)) bus ();

    bonus_spawner dut (
        .clk           (clk),
        .resetN        (resetN),
        .one_sec       (one_sec),
        .blink_tick    (blink_tick),
        .matrixTopLeftX(tlx),
        .matrixTopLeftY(tly),
        .bus           (bus),
        .collision     (collision),
        .randomX       (randomX),
        .randomY       (randomY),
        .drawEn        (drawEn),
        .collected     (collected),
        .expired       (expired),
        .spawn_drop    (spawn_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_cmp(input int code);
        int e;
        e = (exp_q.size() == 0) ? 'hFFFF : exp_q.pop_front();
        check("event", 32'(code), 32'(e));
    endtask

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (resetN) begin
            if (bus.newRandom) pop_cmp(EV_NR);
            if (spawn_drop)    pop_cmp(EV_DROP);
            for (int i = 0; i < NS; i++) begin
                if (collected[i]) pop_cmp(EV_COL + i);
                if (expired[i])   pop_cmp(EV_EXP + i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Candidate pulse, then wait through QUERY and CHECK: on return the
    // CHECK outcome is registered and visible.
    task automatic offer(input int x, input int y);
        bus.randomRise = 1'b1;
        bus.inRandomX  = 5'(x);
        bus.inRandomY  = 4'(y);
        tick();
        bus.randomRise = 1'b0;
        tick();
        tick();
    endtask

    task automatic sec_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            one_sec = 1'b1;
            tick();
            one_sec = 1'b0;
            tick();
        end
    endtask

    initial begin
        resetN = 1'b0; one_sec = 1'b0; blink_tick = 1'b0;
        tlx = 11'd16; tly = 11'd16; collision = '0;
        bus.randomRise = 1'b0; bus.inRandomX = '0; bus.inRandomY = '0;
        bus.map_blocked = 1'b0;
        tick(); tick();

        // reset state
        check("rst_drawEn",    32'(drawEn), 0);
        check("rst_newRandom", 32'(bus.newRandom), 0);
        check("rst_drop",      32'(spawn_drop), 0);
        check("rst_pulses",    32'({collected, expired}), 0);
        check("rst_query",     32'({bus.query_x, bus.query_y}), 0);
        resetN = 1'b1;
        tick();

        // accepted spawn (3,2) into slot 0
        bus.randomRise = 1'b1; bus.inRandomX = 5'd3; bus.inRandomY = 4'd2;
        tick();
        bus.randomRise = 1'b0;
        check("query_x", 32'(bus.query_x), 3);
        check("query_y", 32'(bus.query_y), 2);
        tick(); tick();
        check("pos_x0", 32'(randomX[0]), 113);
        check("pos_y0", 32'(randomY[0]), 81);
        check("draw_lat1", 32'(drawEn), 0);
        tick();
        check("draw_lat2", 32'(drawEn), 4'b0001);

        // three blocked candidates then a clear one -> slot 1
        bus.map_blocked = 1'b1;
        exp_q.push_back(EV_NR); exp_q.push_back(EV_NR); exp_q.push_back(EV_NR);
        offer(5, 5); offer(6, 5); offer(7, 5);
        bus.map_blocked = 1'b0;
        offer(8, 5);
        check("pos_x1", 32'(randomX[1]), 273);
        check("pos_y1", 32'(randomY[1]), 177);

        // four blocked candidates -> dropped, nothing written
        bus.map_blocked = 1'b1;
        exp_q.push_back(EV_NR); exp_q.push_back(EV_NR); exp_q.push_back(EV_NR);
        exp_q.push_back(EV_DROP);
        offer(9, 5); offer(9, 6); offer(9, 7); offer(9, 8);
        bus.map_blocked = 1'b0;
        tick();
        check("drop_nowrite", 32'(drawEn), 4'b0011);

        // occupied cell rejected, then fill slots 2 and 3, then full -> drop
        exp_q.push_back(EV_NR);
        offer(3, 2);
        offer(10, 3);
        offer(11, 3);
        exp_q.push_back(EV_DROP);
        offer(12, 3);
        tick();
        check("full_draw", 32'(drawEn), 4'b1111);
        check("pos_x3", 32'(randomX[3]), 369);
        check("pos_y3", 32'(randomY[3]), 113);

        // lifetime and blink (blink phase is 0 here)
        sec_pulses(11);
        check("age11_draw", 32'(drawEn), 4'b1111);
        sec_pulses(1);
        check("age12_blink0", 32'(drawEn), 4'b0000);
        blink_tick = 1'b1; tick(); blink_tick = 1'b0; tick();
        check("age12_blink1", 32'(drawEn), 4'b1111);
        sec_pulses(2);
        check("age14_draw", 32'(drawEn), 4'b1111);

        // final second: slot 1 collides, the others expire
        exp_q.push_back(EV_EXP + 0); exp_q.push_back(EV_COL + 1);
        exp_q.push_back(EV_EXP + 2); exp_q.push_back(EV_EXP + 3);
        one_sec = 1'b1; collision = 4'b0010;
        tick();
        one_sec = 1'b0; collision = '0;
        check("end_expired",   32'(expired),   4'b1101);
        check("end_collected", 32'(collected), 4'b0010);
        check("end_draw_hold", 32'(drawEn),    4'b1111);
        tick();
        check("end_pulse_once", 32'({collected, expired}), 0);
        check("end_draw_off",   32'(drawEn), 0);

        // collision on an inactive slot is ignored
        collision = 4'b0100;
        tick();
        collision = '0;
        tick();
        check("coll_inactive", 32'(collected), 0);

        // reset mid-operation: two slots live, FSM waiting for a candidate
        offer(1, 1);
        offer(2, 1);
        bus.map_blocked = 1'b1;
        exp_q.push_back(EV_NR);
        offer(4, 4);
        tick();
        check("pre_rst_draw", 32'(drawEn), 4'b0011);
        resetN = 1'b0;
        #1;
        check("mid_rst_draw",  32'(drawEn), 0);
        check("mid_rst_nr",    32'(bus.newRandom), 0);
        check("mid_rst_drop",  32'(spawn_drop), 0);
        tick();
        resetN = 1'b1;
        bus.map_blocked = 1'b0;
        offer(5, 6);
        check("post_rst_x0", 32'(randomX[0]), 177);
        check("post_rst_y0", 32'(randomY[0]), 209);
        tick();
        check("post_rst_draw", 32'(drawEn), 4'b0001);

        tick();
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
